// File: rtl/shared_reg_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
package shared_reg_pkg;

  // Arbiter control states: accept a write, or wait out the hold time.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Supported range for the number of requesters.
  localparam int REQ_MIN = 2;
  localparam int REQ_MAX = 16;

  // Widest requester index the arbiter will ever need.
  localparam int IDX_W_MAX = $clog2(REQ_MAX);

  // Bits needed to hold a requester index, never less than one.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: the first set request above the
// last winner (with wrap-around) gets the grant.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_any,
  output logic [IW-1:0]    o_winner,
  output logic [N_REQ-1:0] o_grant
);

  logic [IW:0] w_sum;

  // Scan from farthest to nearest so the requester just after i_last wins.
  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    o_grant  = '0;
    w_sum    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      w_sum = {1'b0, i_last} + (IW+1)'(off);
      if (w_sum >= (IW+1)'(N_REQ)) begin
        w_sum = w_sum - (IW+1)'(N_REQ);
      end
      if (i_req[w_sum[IW-1:0]]) begin
        o_any                    = 1'b1;
        o_winner                 = w_sum[IW-1:0];
        o_grant                  = '0;
        o_grant[w_sum[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one storage register among N_REQ requesters,
// with a programmable number of idle cycles after every write.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(N_REQ)-1:0]   q_owner,
  output logic                       q_valid,
  output logic                       busy
);

  localparam int IW    = idxWidth(N_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int CNT_LOAD_INT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_INT);

  if (N_REQ < REQ_MIN || N_REQ > REQ_MAX) begin : g_badNReq
    $error("shared_reg_arbiter: N_REQ=%0d outside supported range", N_REQ);
  end

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nextCnt;
  logic [IW-1:0]      r_last;
  logic [WIDTH-1:0]   r_q;
  logic [IW-1:0]      r_owner;
  logic               r_qValid;
  logic               w_fire;
  logic               w_any;
  logic [IW-1:0]      w_winner;
  logic [N_REQ-1:0]   w_grant;
  logic [WIDTH-1:0]   w_winData;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .i_req    (req_valid),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner),
    .o_grant  (w_grant)
  );

  // Select the winning requester's data word; other words never reach q.
  always_comb begin
    w_winData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == IW'(i)) begin
        w_winData = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic: a write happens whenever IDLE sees any request.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_fire = 1'b1;
          if (HOLD_CYCLES > 0) begin
            w_nextState = ST_HOLD;
            w_nextCnt   = CNT_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, counter, pointer and shared register; reset aborts any hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= IW'(N_REQ - 1);
      r_q      <= '0;
      r_owner  <= '0;
      r_qValid <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_qValid <= w_fire;
      if (w_fire) begin
        r_q     <= w_winData;
        r_owner <= w_winner;
        r_last  <= w_winner;
      end
    end
  end

  assign req_ready = (reset_n && w_fire) ? w_grant : '0;
  assign q         = r_q;
  assign q_owner   = r_owner;
  assign q_valid   = r_qValid;
  assign busy      = (r_state == ST_HOLD);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: one instance with a 2-cycle hold and one
// with no hold, both checked every cycle against a round-robin model.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           resetN;
  logic [N-1:0]   reqValid [2];
  logic [N*W-1:0] reqData  [2];
  logic [N-1:0]   reqReady [2];
  logic [W-1:0]   q        [2];
  logic [1:0]     qOwner   [2];
  logic           qValid   [2];
  logic           busy     [2];

  int             mLast  [2];
  int             mHold  [2];
  logic [W-1:0]   mQ     [2];
  int             mOwner [2];
  logic           mQv    [2];
  logic [N-1:0]   mGrant [2];
  bit             mInit;

  logic [N-1:0]   pend [2];
  int             total;
  int             bad;

  always #5 clock = ~clock;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) dutHold (
    .clock     (clock),
    .reset_n   (resetN),
    .req_valid (reqValid[0]),
    .req_data  (reqData[0]),
    .req_ready (reqReady[0]),
    .q         (q[0]),
    .q_owner   (qOwner[0]),
    .q_valid   (qValid[0]),
    .busy      (busy[0])
  );

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(0)) dutNoHold (
    .clock     (clock),
    .reset_n   (resetN),
    .req_valid (reqValid[1]),
    .req_data  (reqData[1]),
    .req_ready (reqReady[1]),
    .q         (q[1]),
    .q_owner   (qOwner[1]),
    .q_valid   (qValid[1]),
    .busy      (busy[1])
  );

  function automatic int holdOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive reset and the request vectors for the coming cycle.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] v0, input logic [N-1:0] v1,
                               input logic [31:0] d0, input logic [31:0] d1);
    resetN      = rst;
    reqValid[0] = v0;
    reqValid[1] = v1;
    reqData[0]  = d0;
    reqData[1]  = d1;
  endtask

  // Check combinational outputs, advance the model, clock, check registers.
  task automatic checkOutput();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] g;
      int           win;
      g   = '0;
      win = 0;
      if (resetN && mHold[d] == 0) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (mLast[d] + k) % N;
          if (reqValid[d][i] && g == '0) begin
            g[i] = 1'b1;
            win  = i;
          end
        end
      end
      check($sformatf("ready%0d", d), 32'(reqReady[d]), 32'(g));
      if (mInit) check($sformatf("busy%0d", d), 32'(busy[d]), 32'(mHold[d] > 0));
      mGrant[d] = g;
      if (!resetN) begin
        mLast[d] = N - 1; mHold[d] = 0; mQ[d] = '0; mOwner[d] = 0; mQv[d] = 1'b0;
      end else if (mHold[d] > 0) begin
        mHold[d]--; mQv[d] = 1'b0;
      end else if (g != '0) begin
        mQ[d] = reqData[d][win*W +: W]; mOwner[d] = win; mLast[d] = win;
        mQv[d] = 1'b1; mHold[d] = holdOf(d);
      end else begin
        mQv[d] = 1'b0;
      end
    end
    if (!resetN) mInit = 1'b1;
    @(posedge clock);
    #1;
    if (mInit) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("q%0d", d), 32'(q[d]), 32'(mQ[d]));
        check($sformatf("owner%0d", d), 32'(qOwner[d]), 32'(mOwner[d]));
        check($sformatf("qvalid%0d", d), 32'(qValid[d]), 32'(mQv[d]));
      end
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] v0, input logic [N-1:0] v1,
                      input logic [31:0] data);
    applyStimulus(rst, v0, v1, data, data);
    checkOutput();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mInit = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mLast[d] = N - 1; mHold[d] = 0; mQ[d] = '0; mOwner[d] = 0; mQv[d] = 1'b0;
      mGrant[d] = '0; pend[d] = '0;
    end

    // Reset with every requester asserting, then rotation through all four.
    step(1'b0, 4'hF, 4'hF, 32'h13121110);
    step(1'b0, 4'hF, 4'hF, 32'h13121110);
    for (int c = 0; c < 15; c++) step(1'b1, 4'hF, 4'hF, 32'h13121110);
    for (int c = 0; c < 3; c++) step(1'b1, 4'h0, 4'h0, $urandom);

    // Single requester 2 writing 0xA5.
    step(1'b1, 4'b0100, 4'b0100, 32'h00A50000);
    check("a5q", 32'(q[0]), 32'hA5);
    check("a5owner", 32'(qOwner[0]), 32'd2);
    for (int c = 0; c < 3; c++) step(1'b1, 4'h0, 4'h0, $urandom);

    // Requesters 1 and 3 alternate; the no-hold instance grants every cycle.
    for (int c = 0; c < 8; c++) step(1'b1, 4'b1010, 4'b1010, $urandom);
    for (int c = 0; c < 3; c++) step(1'b1, 4'h0, 4'h0, $urandom);

    // Reset during the hold, with requester 1 waiting across the reset.
    step(1'b1, 4'b0001, 4'b0001, 32'h0000005C);
    step(1'b0, 4'b0010, 4'b0010, 32'h00000000);
    step(1'b1, 4'b0010, 4'b0010, 32'h00003300);
    check("rstOwner", 32'(qOwner[0]), 32'd1);
    for (int c = 0; c < 3; c++) step(1'b1, 4'h0, 4'h0, $urandom);

    // Requester 1 gives up during the hold; pointer must stay at 0.
    step(1'b0, 4'h0, 4'h0, $urandom);
    step(1'b1, 4'b0011, 4'b0011, $urandom);
    step(1'b1, 4'b0010, 4'b0000, $urandom);
    step(1'b1, 4'b0000, 4'b0000, $urandom);
    step(1'b1, 4'b0000, 4'b0000, $urandom);
    step(1'b1, 4'b0011, 4'b0011, $urandom);
    for (int c = 0; c < 3; c++) step(1'b1, 4'h0, 4'h0, $urandom);

    // Random traffic: requesters hold valid until granted, occasionally drop.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[d][i] && $urandom_range(0, 2) == 0) pend[d][i] = 1'b1;
          else if ($urandom_range(0, 15) == 0) pend[d][i] = 1'b0;
        end
      end
      applyStimulus(($urandom_range(0, 59) != 0), pend[0], pend[1], $urandom, $urandom);
      checkOutput();
      for (int d = 0; d < 2; d++) pend[d] = pend[d] & ~mGrant[d];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
